// File: rtl/key_click_decoder.sv
// Push-button front end: synchronise and debounce an active-low key, then
// classify each gesture as single click, double click or long press.
module key_click_decoder #(
  parameter int DEB_CNT  = 1_000_000,
  parameter int LONG_CNT = 50_000_000,
  parameter int DBL_GAP  = 15_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key,
  output logic key_out,
  output logic single_flag,
  output logic double_flag,
  output logic long_flag
);

  localparam int DW   = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int TMAX = (LONG_CNT > DBL_GAP) ? LONG_CNT : DBL_GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CNT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(DBL_GAP - 1);
  localparam logic [TW-1:0] T_SAT     = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  logic          key_s1_q, key_s2_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          key_out_q, key_out_d;
  logic          key_prev_q;
  logic          press_s, release_s;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          single_q, double_q, long_q;

  // Debounce: a new level must persist DEB_CNT cycles before it is accepted.
  always_comb begin
    deb_cnt_d = '0;
    key_out_d = key_out_q;
    if (key_s2_q != key_out_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        key_out_d = key_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      deb_cnt_q  <= '0;
      key_out_q  <= 1'b1;
      key_prev_q <= 1'b1;
    end else begin
      key_s1_q   <= key;
      key_s2_q   <= key_s1_q;
      deb_cnt_q  <= deb_cnt_d;
      key_out_q  <= key_out_d;
      key_prev_q <= key_out_q;
    end
  end

  assign press_s   = key_prev_q & ~key_out_q;
  assign release_s = ~key_prev_q & key_out_q;

  // Gesture classifier; edge strobes take priority over timer expiry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      if (timer_q != T_SAT) timer_q <= timer_q + TW'(1);
      case (state_q)
        IDLE: begin
          if (press_s) begin
            state_q <= PRESS1;
            timer_q <= '0;
          end
        end
        PRESS1: begin
          if (release_s) begin
            state_q <= WAIT2;
            timer_q <= '0;
          end else if (timer_q == LONG_LAST) begin
            long_q  <= 1'b1;
            state_q <= LONG_HOLD;
            timer_q <= '0;
          end
        end
        LONG_HOLD: begin
          if (release_s) begin
            state_q <= IDLE;
            timer_q <= '0;
          end
        end
        WAIT2: begin
          if (press_s) begin
            state_q <= PRESS2;
            timer_q <= '0;
          end else if (timer_q == GAP_LAST) begin
            single_q <= 1'b1;
            state_q  <= IDLE;
            timer_q  <= '0;
          end
        end
        PRESS2: begin
          if (release_s) begin
            double_q <= 1'b1;
            state_q  <= IDLE;
            timer_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign key_out     = key_out_q;
  assign single_flag = single_q;
  assign double_flag = double_q;
  assign long_flag   = long_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// Bench for key_click_decoder: directed gestures plus random key waveforms,
// compared every cycle against a deadline-based gesture model.
module tb_key_click_decoder;

  localparam int DEB_CNT  = 4;
  localparam int LONG_CNT = 40;
  localparam int DBL_GAP  = 20;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic key     = 1'b1;
  logic key_out, single_flag, double_flag, long_flag;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  key_click_decoder #(
    .DEB_CNT (DEB_CNT),
    .LONG_CNT(LONG_CNT),
    .DBL_GAP (DBL_GAP)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_out    (key_out),
    .single_flag(single_flag),
    .double_flag(double_flag),
    .long_flag  (long_flag)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Gesture stages tracked with absolute-cycle deadlines instead of a timer.
  localparam int G_NONE = 0, G_HELD = 1, G_GAP = 2, G_LONG = 3, G_SECOND = 4;
  int   edge_n = 0, deadline = 0, run = 0, stage = G_NONE;
  logic raw_d1 = 1'b1, raw_d2 = 1'b1, m_key = 1'b1, m_key_prev = 1'b1;
  logic m_s = 1'b0, m_d = 1'b0, m_l = 1'b0;
  logic pressed, released;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_d1 = 1'b1; raw_d2 = 1'b1; m_key = 1'b1; m_key_prev = 1'b1;
      run = 0; stage = G_NONE; deadline = 0;
      m_s = 1'b0; m_d = 1'b0; m_l = 1'b0;
    end else begin
      edge_n++;
      pressed  = m_key_prev && !m_key;
      released = !m_key_prev && m_key;
      m_s = 1'b0; m_d = 1'b0; m_l = 1'b0;
      case (stage)
        G_NONE:   if (pressed) begin stage = G_HELD; deadline = edge_n + LONG_CNT; end
        G_HELD:   if (released) begin stage = G_GAP; deadline = edge_n + DBL_GAP; end
                  else if (edge_n == deadline) begin m_l = 1'b1; stage = G_LONG; end
        G_LONG:   if (released) stage = G_NONE;
        G_GAP:    if (pressed) stage = G_SECOND;
                  else if (edge_n == deadline) begin m_s = 1'b1; stage = G_NONE; end
        G_SECOND: if (released) begin m_d = 1'b1; stage = G_NONE; end
        default:  stage = G_NONE;
      endcase
      m_key_prev = m_key;
      // level seen two edges ago must disagree DEB_CNT edges in a row
      if (raw_d2 != m_key) begin
        run++;
        if (run == DEB_CNT) begin m_key = raw_d2; run = 0; end
      end else begin
        run = 0;
      end
      raw_d2 = raw_d1;
      raw_d1 = key;
    end
  end

  // ---------------- scoreboard: per-cycle compare + flag counters ----------------
  int n_s = 0, n_d = 0, n_l = 0;
  int b_s = 0, b_d = 0, b_l = 0;

  always @(negedge sys_clk) begin
    if (single_flag) n_s++;
    if (double_flag) n_d++;
    if (long_flag)   n_l++;
    if (chk_en)
      check_eq("outs{key_out,s,d,l}", {28'd0, key_out, single_flag, double_flag, long_flag},
               {28'd0, m_key, m_s, m_d, m_l});
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic level, input int n);
    key = level;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_key_out", {31'd0, key_out}, 32'd1);
    check_eq("rst_flags", {29'd0, single_flag, double_flag, long_flag}, 32'd0);
    repeat (n) @(negedge sys_clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic mark();
    b_s = n_s; b_d = n_d; b_l = n_l;
  endtask

  task automatic expect_counts(input string tag, input int es, input int ed, input int el);
    check_eq({tag, "_single"}, n_s - b_s, es);
    check_eq({tag, "_double"}, n_d - b_d, ed);
    check_eq({tag, "_long"},   n_l - b_l, el);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    key = 1'b1;
    rst_n = 1'b0;
    @(posedge sys_clk);
    chk_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_eq("reset_key_out", {31'd0, key_out}, 32'd1);
    #2 rst_n = 1'b1;
    hold(1'b1, 10);

    mark(); hold(1'b0, 10); hold(1'b1, 60);
    expect_counts("single_click", 1, 0, 0);

    mark(); hold(1'b0, 10); hold(1'b1, 8); hold(1'b0, 10); hold(1'b1, 60);
    expect_counts("double_click", 0, 1, 0);

    mark(); hold(1'b0, 60); hold(1'b1, 60);
    expect_counts("long_press", 0, 0, 1);

    mark();
    for (int i = 0; i < 15; i++) hold(i[0] ? 1'b1 : 1'b0, 2);
    hold(1'b1, 40);
    expect_counts("bounce", 0, 0, 0);
    check_eq("bounce_key_out", {31'd0, key_out}, 32'd1);

    // second press reaches the classifier on the same edge the gap expires
    mark(); hold(1'b0, 10); hold(1'b1, 20); hold(1'b0, 10); hold(1'b1, 60);
    expect_counts("gap_tie", 0, 1, 0);

    // reset while the first press is held, timer around 25
    mark(); hold(1'b0, 32);
    key = 1'b1;
    do_reset(3);
    hold(1'b1, 80);
    expect_counts("reset_mid_press", 0, 0, 0);

    // key held low across reset release still yields a long press
    key = 1'b0;
    do_reset(3);
    mark(); hold(1'b0, 60); hold(1'b1, 60);
    expect_counts("held_through_reset", 0, 0, 1);

    // random waveforms: bounces, clicks, gaps and long holds
    for (int seg = 0; seg < 300; seg++) begin
      int cls, dur;
      cls = $urandom_range(0, 3);
      case (cls)
        0:       dur = $urandom_range(1, 3);
        1:       dur = $urandom_range(5, 15);
        2:       dur = $urandom_range(16, 30);
        default: dur = $urandom_range(38, 70);
      endcase
      hold(~key, dur);
      if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 4));
    end
    hold(1'b1, 120);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
